// File: rtl/sobel_rgb_axis_mul_pipe.sv
// Pipelined signed/unsigned multiplier with valid/ready handshake and a user tag.
// Stalled stages hold; empty stages ahead of a stall keep filling (bubble collapse).
module sobel_rgb_axis_mul_pipe #(
  parameter int unsigned din0_WIDTH = 31,
  parameter int unsigned din1_WIDTH = 31,
  parameter int unsigned dout_WIDTH = 62,
  parameter int unsigned NUM_STAGE  = 3,
  parameter int unsigned USER_WIDTH = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  is_signed,
  input  logic [USER_WIDTH-1:0] in_user,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [USER_WIDTH-1:0] out_user
);

  localparam int unsigned ProdWidth = din0_WIDTH + din1_WIDTH + 2;

  logic [NUM_STAGE-1:0]  valid_q;
  logic [dout_WIDTH-1:0] prod_q [NUM_STAGE];
  logic [USER_WIDTH-1:0] user_q [NUM_STAGE];
  logic [NUM_STAGE-1:0]  load;

  logic signed [din0_WIDTH:0]  op0_x;
  logic signed [din1_WIDTH:0]  op1_x;
  logic signed [ProdWidth-1:0] prod_full;
  logic [dout_WIDTH-1:0]       prod_d;

  // One extra bit per operand makes a single signed multiply cover both modes; the exact
  // product is then sign-extended or truncated, matching a multiply at dout_WIDTH.
  assign op0_x     = $signed({is_signed & din0[din0_WIDTH-1], din0});
  assign op1_x     = $signed({is_signed & din1[din1_WIDTH-1], din1});
  assign prod_full = op0_x * op1_x;
  assign prod_d    = dout_WIDTH'(prod_full);

  // A stage may load if it or any stage downstream of it frees a slot this cycle.
  always_comb begin
    logic run;
    load = '0;
    run  = out_ready;
    for (int k = int'(NUM_STAGE) - 1; k >= 0; k--) begin
      run     = run | ~valid_q[k];
      load[k] = run;
    end
  end

  assign in_ready = load[0];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < int'(NUM_STAGE); k++) begin
        prod_q[k] <= '0;
        user_q[k] <= '0;
      end
    end else begin
      if (load[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          prod_q[0] <= prod_d;
          user_q[0] <= in_user;
        end
      end
      for (int k = 1; k < int'(NUM_STAGE); k++) begin
        if (load[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            prod_q[k] <= prod_q[k-1];
            user_q[k] <= user_q[k-1];
          end
        end
      end
    end
  end

  assign out_valid = valid_q[NUM_STAGE-1];
  assign dout      = prod_q[NUM_STAGE-1];
  assign out_user  = user_q[NUM_STAGE-1];

endmodule

// File: tb/tb_sobel_rgb_axis_mul_pipe.sv
// Bench for sobel_rgb_axis_mul_pipe: directed test-plan steps plus a random phase,
// checked every cycle against a queue-based transaction model.
module tb_sobel_rgb_axis_mul_pipe;

  localparam int W0 = 31;
  localparam int W1 = 31;
  localparam int WD = 62;
  localparam int NS = 3;
  localparam int WU = 8;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W0-1:0] din0;
  logic [W1-1:0] din1;
  logic          is_signed;
  logic [WU-1:0] in_user;
  logic          out_valid;
  logic          out_ready;
  logic [WD-1:0] dout;
  logic [WU-1:0] out_user;

  always #5 ap_clk = ~ap_clk;

  sobel_rgb_axis_mul_pipe #(
    .din0_WIDTH(W0),
    .din1_WIDTH(W1),
    .dout_WIDTH(WD),
    .NUM_STAGE (NS),
    .USER_WIDTH(WU)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din0     (din0),
    .din1     (din1),
    .is_signed(is_signed),
    .in_user  (in_user),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout),
    .out_user (out_user)
  );

  typedef struct {
    logic [WD-1:0] prod;
    logic [WU-1:0] user;
    int            acc;
  } item_t;

  item_t q[$];
  int    edges    = 0;
  int    checks   = 0;
  int    failures = 0;

  function automatic logic [WD-1:0] ref_mul(logic [W0-1:0] a, logic [W1-1:0] b, logic s);
    longint x, y, p;
    x = s ? longint'({{(64-W0){a[W0-1]}}, a}) : longint'({{(64-W0){1'b0}}, a});
    y = s ? longint'({{(64-W1){b[W1-1]}}, b}) : longint'({{(64-W1){1'b0}}, b});
    p = x * y;
    return p[WD-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic cycle(output logic fin);
    logic exp_ov, exp_ir, fout;
    @(negedge ap_clk);
    exp_ov = 1'b0;
    if (q.size() > 0) exp_ov = (edges - q[0].acc) >= NS - 1;
    exp_ir = (q.size() < NS) || out_ready;
    chk("out_valid", {63'b0, out_valid}, {63'b0, exp_ov});
    chk("in_ready", {63'b0, in_ready}, {63'b0, exp_ir});
    if (exp_ov) begin
      chk("dout", {2'b0, dout}, {2'b0, q[0].prod});
      chk("out_user", {56'b0, out_user}, {56'b0, q[0].user});
    end
    fin  = in_valid && exp_ir;
    fout = exp_ov && out_ready;
    @(posedge ap_clk);
    edges++;
    if (fout) void'(q.pop_front());
    if (fin) begin
      item_t it;
      it.prod = ref_mul(din0, din1, is_signed);
      it.user = in_user;
      it.acc  = edges;
      q.push_back(it);
    end
    #1;
  endtask

  task automatic new_op();
    din0      = W0'($urandom());
    din1      = W1'($urandom());
    is_signed = 1'($urandom());
    in_user   = WU'($urandom());
  endtask

  initial begin
    logic fin;
    int   n;
    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    din0      = '0;
    din1      = '0;
    is_signed = 1'b0;
    in_user   = '0;
    out_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_dout", {2'b0, dout}, 64'd0);
    chk("rst_out_user", {56'b0, out_user}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    #10 ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;

    // Unsigned max: visible after accept edge + 2, valid for exactly one cycle
    din0 = 31'h7FFF_FFFF; din1 = 31'h7FFF_FFFF; is_signed = 1'b0; in_user = 8'hA5;
    in_valid = 1'b1;
    cycle(fin);
    chk("umax_accept", {63'b0, fin}, 64'd1);
    in_valid = 1'b0;
    cycle(fin);
    cycle(fin);
    chk("umax_valid", {63'b0, out_valid}, 64'd1);
    chk("umax_dout", {2'b0, dout}, 64'h3FFF_FFFF_0000_0001);
    chk("umax_user", {56'b0, out_user}, 64'hA5);
    cycle(fin);
    chk("umax_one_cycle", {63'b0, out_valid}, 64'd0);

    // Signed vs unsigned interpretation of the same operands
    din0 = 31'h7FFF_FFFF; din1 = 31'd5; is_signed = 1'b1; in_user = 8'h01;
    in_valid = 1'b1;
    cycle(fin);
    is_signed = 1'b0; in_user = 8'h02;
    cycle(fin);
    in_valid = 1'b0;
    cycle(fin);
    chk("signed_dout", {2'b0, dout}, 64'h3FFF_FFFF_FFFF_FFFB);
    cycle(fin);
    chk("unsigned_dout", {2'b0, dout}, 64'h0000_0002_7FFF_FFFB);
    cycle(fin);

    // Streaming: back-to-back with out_ready held high
    for (int i = 0; i < 8; i++) begin
      din0 = W0'(i); din1 = W1'(i + 1); is_signed = 1'b0; in_user = WU'(i);
      in_valid = 1'b1;
      chk("stream_in_ready", {63'b0, in_ready}, 64'd1);
      cycle(fin);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle(fin);

    // Backpressure: exactly NS accepts while the output stalls
    out_ready = 1'b0;
    new_op();
    in_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(fin);
      if (fin) begin
        n++;
        new_op();
      end
    end
    chk("bp_accepts", 64'(n), 64'(NS));
    chk("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle(fin);

    // Bubble collapse: A stalls at the output, B and C close up behind it
    new_op();
    in_valid = 1'b1;
    cycle(fin);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cycle(fin);
    cycle(fin);
    for (int i = 0; i < 2; i++) begin
      new_op();
      in_valid = 1'b1;
      cycle(fin);
      chk("bubble_accept", {63'b0, fin}, 64'd1);
    end
    in_valid = 1'b0;
    chk("bubble_full", {63'b0, in_ready}, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bubble_drain_valid", {63'b0, out_valid}, 64'd1);
      cycle(fin);
    end
    chk("bubble_empty", {63'b0, out_valid}, 64'd0);

    // Reset mid-stream discards in-flight results
    for (int i = 0; i < 2; i++) begin
      new_op();
      in_valid = 1'b1;
      cycle(fin);
    end
    in_valid = 1'b0;
    #1 ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("mid_rst_dout", {2'b0, dout}, 64'd0);
    chk("mid_rst_out_user", {56'b0, out_user}, 64'd0);
    q.delete();
    #1 ap_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(fin);
    din0 = 31'd123; din1 = 31'd456; is_signed = 1'b0; in_user = 8'h3C;
    in_valid = 1'b1;
    cycle(fin);
    in_valid = 1'b0;
    cycle(fin);
    cycle(fin);
    chk("post_rst_valid", {63'b0, out_valid}, 64'd1);
    chk("post_rst_dout", {2'b0, dout}, 64'd56088);
    cycle(fin);

    // Random traffic; operands held until accepted
    new_op();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle(fin);
      if (fin) new_op();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle(fin);
    chk("final_drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
